counter_ctrl: RTL and testbench

- Upstream stage of the seven-segment/LED display decoder.
- Turns three raw push-buttons into the 5-bit counter value and the display-mode flag that the decoder consumes (o_data feeds its i_data, o_type feeds its i_type).
- Handles synchronisation, debouncing, press detection with hold-to-repeat, and a wrapping up/down counter with a BIN/DEC mode toggle.

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_ctrl_btn_debounce.sv | 55 +++++
 rtl/counter_ctrl.sv | 135 +++++++++++++
 tb/tb_counter_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the push-button counter front end of the display decoder.
package counter_pkg;

    localparam int DATA_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } repeat_state_t;

endpackage

// File: rtl/counter_ctrl_btn_debounce.sv
// Per-button conditioning: inversion, 2-flop synchroniser, debounce and
// a one-cycle press pulse on each accepted released->pressed transition.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            meta_q  <= ~i_btn_n;
            sync_q  <= meta_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign o_level = level_q;
    assign o_press = press_q;

endmodule

// File: rtl/counter_ctrl.sv
// Three debounced keys drive a wrapping 5-bit up/down counter with
// hold-to-repeat on inc/dec and a BIN/DEC display mode toggle.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_btn_inc,
    input  logic              i_btn_dec,
    input  logic              i_btn_mode,
    output logic [DATA_W-1:0] o_data,
    output logic              o_type
);

    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(TMAX + 2);
    localparam logic [CW-1:0] HOLD_LAST =
        CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] REP_LAST =
        CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    // index 0 = inc, 1 = dec
    logic [1:0]        lvl;
    logic [1:0]        prs;
    logic [1:0]        step;
    logic              mode_press;
    logic              unused_mode_level;

    repeat_state_t     st_q [2];
    repeat_state_t     st_d [2];
    logic [CW-1:0]     tm_q [2];
    logic [CW-1:0]     tm_d [2];

    logic [DATA_W-1:0] data_q, data_d;
    logic              type_q, type_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn_n (i_btn_inc),
        .o_level (lvl[0]),
        .o_press (prs[0])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn_n (i_btn_dec),
        .o_level (lvl[1]),
        .o_press (prs[1])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn_n (i_btn_mode),
        .o_level (unused_mode_level),
        .o_press (mode_press)
    );

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i] = st_q[i];
            tm_d[i] = '0;
            step[i] = 1'b0;
            unique case (st_q[i])
                IDLE: begin
                    if (prs[i]) begin
                        st_d[i] = HOLD;
                        step[i] = 1'b1;
                    end
                end
                HOLD: begin
                    if (!lvl[i]) begin
                        st_d[i] = IDLE;
                    end else if (HOLD_CYCLES != 0) begin
                        if (tm_q[i] == HOLD_LAST) begin
                            st_d[i] = REPEAT;
                            step[i] = 1'b1;
                        end else begin
                            tm_d[i] = tm_q[i] + CW'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (!lvl[i]) begin
                        st_d[i] = IDLE;
                    end else if (tm_q[i] == REP_LAST) begin
                        step[i] = 1'b1;
                    end else begin
                        tm_d[i] = tm_q[i] + CW'(1);
                    end
                end
                default: st_d[i] = IDLE;
            endcase
        end
    end

    // Opposing steps in the same cycle cancel out.
    always_comb begin
        data_d = data_q;
        if (step[0] && !step[1]) begin
            data_d = data_q + DATA_W'(1);
        end else if (step[1] && !step[0]) begin
            data_d = data_q - DATA_W'(1);
        end
        type_d = type_q ^ mode_press;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i] <= IDLE;
                tm_q[i] <= '0;
            end
            data_q <= '0;
            type_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i] <= st_d[i];
                tm_q[i] <= tm_d[i];
            end
            data_q <= data_d;
            type_q <= type_d;
        end
    end

    assign o_data = data_q;
    assign o_type = type_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random key activity,
// checked every cycle against an edge-count based reference model.
module tb_counter_ctrl;

    localparam int DB   = 4;
    localparam int H    = 20;
    localparam int R    = 8;
    localparam int MAXE = 16384;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_btn_inc;
    logic       i_btn_dec;
    logic       i_btn_mode;
    logic [4:0] o_data;
    logic       o_type;

    int n_tests = 0;
    int n_fail  = 0;

    counter_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_btn_inc  (i_btn_inc),
        .i_btn_dec  (i_btn_dec),
        .i_btn_mode (i_btn_mode),
        .o_data     (o_data),
        .o_type     (o_type)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: raw active-high samples per edge; a key is accepted
    // once DB consecutive synced samples (raw delayed by 2) disagree.
    // Steps follow from the edge count since the press was accepted.
    bit [2:0] raw_hist [0:MAXE-1];
    int       ecnt     = 0;
    int       last_rst = -100;
    bit       acc  [3];
    int       base [3];
    int       m_data = 0;
    bit       m_type = 1'b0;
    bit       st   [3];
    bit       flip;
    int       t;

    function automatic bit syn_at(input int b, input int n);
        if (n - 2 <= last_rst || n - 2 < 0) return 1'b0;
        return raw_hist[n-2][b];
    endfunction

    always @(posedge i_clk) begin
        if (ecnt < MAXE)
            raw_hist[ecnt] = {~i_btn_mode, ~i_btn_dec, ~i_btn_inc};
        if (i_rst) begin
            last_rst = ecnt;
            for (int b = 0; b < 3; b++) begin
                acc[b]  = 1'b0;
                base[b] = -1;
            end
            m_data = 0;
            m_type = 1'b0;
        end else begin
            for (int b = 0; b < 3; b++) begin
                st[b] = 1'b0;
                if (acc[b] && base[b] >= 0) begin
                    t = ecnt - base[b];
                    if (b == 2)
                        st[b] = (t == 0);
                    else
                        st[b] = (t == 0) || (t >= H && (t - H) % R == 0);
                end
            end
            for (int b = 0; b < 3; b++) begin
                flip = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (ecnt - k <= last_rst || syn_at(b, ecnt - k) == acc[b])
                        flip = 1'b0;
                if (flip) begin
                    acc[b]  = ~acc[b];
                    base[b] = acc[b] ? ecnt + 1 : -1;
                end
            end
            if (st[0] && !st[1]) m_data = (m_data + 1) % 32;
            else if (st[1] && !st[0]) m_data = (m_data + 31) % 32;
            if (st[2]) m_type = ~m_type;
        end
        ecnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge i_clk);
        chk("model_data", int'(o_data), m_data);
        chk("model_type", int'(o_type), int'(m_type));
    endtask

    task automatic drive(input bit [2:0] mask);
        i_btn_inc  = ~mask[0];
        i_btn_dec  = ~mask[1];
        i_btn_mode = ~mask[2];
    endtask

    // Press the masked keys for 'hold' cycles, report cycles to first
    // o_data change (99 if none), then release and settle.
    task automatic press(input bit [2:0] mask, input int hold, output int lat);
        int old;
        old = int'(o_data);
        lat = 99;
        drive(mask);
        for (int i = 1; i <= hold; i++) begin
            cyc();
            if (int'(o_data) != old && lat == 99) lat = i;
        end
        drive(3'b000);
        repeat (15) cyc();
    endtask

    task automatic wait_change(input bit on_type, output int lat);
        int old;
        old = on_type ? int'(o_type) : int'(o_data);
        lat = 99;
        for (int i = 1; i <= 30; i++) begin
            cyc();
            if ((on_type ? int'(o_type) : int'(o_data)) != old) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int len;
        i_rst = 1'b1;
        drive(3'b000);
        repeat (3) cyc();
        chk("reset_data", int'(o_data), 0);
        chk("reset_type", int'(o_type), 0);
        i_rst = 1'b0;
        repeat (5) cyc();

        press(3'b001, 10, lat);
        chk("basic_latency_ok", int'(lat >= 6 && lat <= 8), 1);
        chk("basic_data", int'(o_data), 1);
        chk("basic_type", int'(o_type), 0);

        for (int i = 0; i < 5; i++) begin
            drive(3'b010);
            repeat (2) cyc();
            drive(3'b000);
            repeat (2) cyc();
        end
        repeat (15) cyc();
        chk("bounce_data", int'(o_data), 1);

        press(3'b010, 10, lat);
        chk("dec_to_0", int'(o_data), 0);
        press(3'b010, 10, lat);
        chk("dec_wrap", int'(o_data), 31);
        press(3'b001, 10, lat);
        chk("inc_wrap", int'(o_data), 0);

        drive(3'b001);
        wait_change(1'b0, lat);
        chk("rep_first", int'(o_data), 1);
        for (int k = 1; k <= 53; k++) begin
            cyc();
            if (k == 19) chk("rep_before_hold", int'(o_data), 1);
            if (k == 20) chk("rep_at_hold", int'(o_data), 2);
            if (k == 28) chk("rep_first_period", int'(o_data), 3);
            if (k == 53) chk("rep_at_release", int'(o_data), 6);
        end
        drive(3'b000);
        repeat (20) cyc();
        chk("rep_after_release", int'(o_data), 6);

        press(3'b011, 10, lat);
        chk("inc_dec_cancel", int'(o_data), 6);

        drive(3'b101);
        wait_change(1'b1, lat);
        chk("mode_inc_type", int'(o_type), 1);
        chk("mode_inc_data", int'(o_data), 7);
        repeat (8) cyc();
        drive(3'b000);
        repeat (15) cyc();

        drive(3'b001);
        wait_change(1'b0, lat);
        chk("pre_rst_data", int'(o_data), 8);
        repeat (10) cyc();
        i_rst = 1'b1;
        repeat (2) cyc();
        chk("midpress_rst_data", int'(o_data), 0);
        chk("midpress_rst_type", int'(o_type), 0);
        i_rst = 1'b0;
        wait_change(1'b0, lat);
        chk("post_rst_latency_ok", int'(lat >= 6 && lat <= 8), 1);
        chk("post_rst_data", int'(o_data), 1);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 19) chk("post_rst_hold", int'(o_data), 1);
            if (k == 20) chk("post_rst_repeat", int'(o_data), 2);
        end
        drive(3'b000);
        repeat (15) cyc();

        for (int s = 0; s < 50; s++) begin
            if ($urandom_range(0, 14) == 0) begin
                i_rst = 1'b1;
                repeat ($urandom_range(1, 3)) cyc();
                i_rst = 1'b0;
            end
            drive(3'($urandom_range(0, 7)));
            len = $urandom_range(1, 32);
            repeat (len) cyc();
        end
        drive(3'b000);
        repeat (40) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
